game_ctrl: RTL and testbench
============================

# game_ctrl

Two-player reaction-duel game controller. Consumes the debounced one-shot strobes from the button controller (`start`, `restart`, `play[1:0]`) and the shared 1 ms tick. Sequences rounds through countdown, random arming delay, reaction measurement and result hold. Keeps the score and drives the state and result signals read by the LCD/LED display logic.

## Interface
- `COUNTDOWN_MS`, 3000: READY duration in ticks.
- `RAND_MIN_MS`, 1000: minimum ARMED delay.
- `RAND_MASK`, 16'h07FF: mask applied to the LFSR to form the random delay increment (0..2047 ms).
- `TIMEOUT_MS`, 5000: GO duration with no press before the round is void.
- `RESULT_MS`, 2000: ROUND_END hold time.
- `WIN_SCORE`, 5: score that ends the game; range 1..15.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_tick` in 1: 1 ms tick, one `clk` wide.
- `i_start` in 1: start one-shot.
- `i_restart` in 1: restart one-shot.
- `i_play` in 2: play one-shots; [0] is the left player, [1] is the right player.
- `o_state` out 3: current state code.
- `o_go` out 1: GO lamp; high only in GO.
- `o_score_l` out 4: left player score.
- `o_score_r` out 4: right player score.
- `o_winner` out 2: last round winner; 01 = L, 10 = R, 00 = none/tie.
- `o_foul` out 2: last round false-start flags, per player.
- `o_react_ms` out 14: last winning reaction time, saturating at 9999.
- `o_game_over` out 1: high in GAME_OVER.

## Operation
- States and codes: IDLE=0, READY=1, ARMED=2, GO=3, ROUND_END=4, GAME_OVER=5.
- Reset values: state IDLE; all outputs 0; all counters 0; LFSR at its seed.
- `i_restart` in any state other than IDLE: go to IDLE, clear scores, winner, foul and react. Restart has priority over every other event in the same cycle.
- IDLE: on `i_start`, clear scores, winner, foul and react, then enter READY. `i_play` is ignored.
- READY: count ticks. After `COUNTDOWN_MS` ticks, enter ARMED and latch `delay = RAND_MIN_MS + (lfsr & RAND_MASK)` (17-bit sum). Presses are ignored; they are not fouls.
- ARMED: any press is a foul.
  - Single press: set that player's foul bit, credit the opponent with one point, and set `o_winner` to the opponent.
  - Both players press in the same cycle: foul=11, winner=00, no score change.
  - Either case enters ROUND_END.
  - If no press, enter GO after `delay` ticks and clear the reaction counter.
  - A press in the same cycle as delay expiry counts as a foul.
- GO: the reaction counter increments on each tick and saturates at 9999.
  - First press wins: that player scores +1, `o_winner` is set, and `o_react_ms` takes the counter value.
  - Both players press in the same cycle: tie, winner=00, no score change, `o_react_ms` still updated.
  - If `TIMEOUT_MS` ticks pass with no press: winner=00, foul=00, react=0.
  - A press in the same cycle as timeout wins.
  - All cases enter ROUND_END.
- ROUND_END: hold for `RESULT_MS` ticks. If either score equals `WIN_SCORE`, enter GAME_OVER; otherwise enter READY and clear winner/foul. `o_react_ms` is kept until the next result.
- GAME_OVER: scores are frozen. `i_start` clears scores and enters READY; `i_restart` enters IDLE.
- Scores never exceed `WIN_SCORE`. Only one score can change per round.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11, seed 16'hACE1. It advances every `clk` (not every tick), so delays depend on human timing.

## Timing
- All outputs are registered. State and outputs change on the `clk` edge after the strobe or tick that causes them; latency is one cycle.
- Tick counters clear on state entry. Expiry is the cycle where `i_tick`=1 and the count equals N-1, so a phase lasts exactly N ticks. The first partial tick period counts as a whole tick.
- `o_go` rises on the same edge as the state becomes GO.
- Strobes arriving while `rst` is asserted are lost. Reset mid-round returns everything to the reset values immediately.

## Structure
- Shared package `game_pkg`: state code localparams, winner codes (WIN_NONE/L/R), and play bit indices (PLAY_L=0, PLAY_R=1). The display logic uses the same package.
- Sub-module `lfsr16`: ports `clk`, `rst`, `o_value[15:0]`. It has its own tests.
- Everything else (FSM, tick counter, scoring) lives in `game_ctrl`.

## Test plan
- Reset, then `i_start` -> READY next cycle. 3000 ticks later -> ARMED, and `delay` lies in 1000..3047.
- ARMED, left press -> ROUND_END, foul=01, winner=10, score_r=1. 2000 ticks later -> READY with foul/winner cleared.
- GO, right press after 250 ticks -> winner=10, react=250. A both-press in GO -> winner=00, scores unchanged.
- GO, no press for 5000 ticks -> ROUND_END, winner=00. A press on the timeout cycle -> that player wins.
- Left wins 5 rounds -> GAME_OVER, `o_game_over`=1, score_l=5. `i_start` -> READY with scores 0.
- `i_restart` together with `i_play` in GO -> IDLE with scores 0 and no score credited. `rst` pulsed mid-ARMED -> all outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Brief    : Shared state codes, winner codes and play indices for the
//             reaction-duel controller and its display logic.
//  Revision : 1.0
// ============================================================================
package game_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READY     = 3'd1;
  localparam logic [2:0] ST_ARMED     = 3'd2;
  localparam logic [2:0] ST_GO        = 3'd3;
  localparam logic [2:0] ST_ROUND_END = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_READY     = ST_READY,
    S_ARMED     = ST_ARMED,
    S_GO        = ST_GO,
    S_ROUND_END = ST_ROUND_END,
    S_GAME_OVER = ST_GAME_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  localparam int PLAY_L = 0;
  localparam int PLAY_R = 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          CNT_W     = 17;
  localparam int          REACT_W   = 14;
  localparam logic [13:0] REACT_MAX = 14'd9999;

  // Scores stop at the winning value even if a stray credit arrives.
  function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s < lim) ? s + 4'd1 : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Brief    : Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11.
//  Revision : 1.0
// ============================================================================
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Brief    : Two-player reaction-duel controller: round sequencing, timing
//             and scoring.
//  Revision : 1.0
// ============================================================================
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_MS = 3000,
  parameter int unsigned RAND_MIN_MS  = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h07FF,
  parameter int unsigned TIMEOUT_MS   = 5000,
  parameter int unsigned RESULT_MS    = 2000,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic        i_restart,
  input  logic [1:0]  i_play,
  output logic [2:0]  o_state,
  output logic        o_go,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic [1:0]  o_winner,
  output logic [1:0]  o_foul,
  output logic [13:0] o_react_ms,
  output logic        o_game_over
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   delay_q, delay_d;
  logic [REACT_W-1:0] react_cnt_q, react_cnt_d;
  logic [REACT_W-1:0] react_q, react_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic [1:0]         foul_q, foul_d;
  logic               go_q, go_d;
  logic               game_over_q, game_over_d;

  logic [15:0]        w_lfsr;
  logic [CNT_W-1:0]   w_limit;
  logic               w_timed;
  logic               w_expire;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_value (w_lfsr)
  );

  always_comb begin
    w_limit = '0;
    w_timed = 1'b1;
    case (state_q)
      S_READY:     w_limit = CNT_W'(COUNTDOWN_MS);
      S_ARMED:     w_limit = delay_q;
      S_GO:        w_limit = CNT_W'(TIMEOUT_MS);
      S_ROUND_END: w_limit = CNT_W'(RESULT_MS);
      default:     w_timed = 1'b0;
    endcase
    w_expire = w_timed && i_tick && (cnt_q == w_limit - CNT_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    delay_d     = delay_q;
    react_cnt_d = react_cnt_q;
    react_d     = react_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    foul_d      = foul_q;

    if (w_timed && i_tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (i_restart && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = WIN_NONE;
      foul_d    = 2'b00;
      react_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_GAME_OVER: begin
          if (i_start) begin
            state_d   = S_READY;
            score_l_d = '0;
            score_r_d = '0;
            winner_d  = WIN_NONE;
            foul_d    = 2'b00;
            react_d   = '0;
          end
        end
        S_READY: begin
          if (w_expire) begin
            state_d = S_ARMED;
            delay_d = CNT_W'(RAND_MIN_MS) + {1'b0, w_lfsr & RAND_MASK};
          end
        end
        S_ARMED: begin
          // A press beats delay expiry in the same cycle: still a false start.
          if (&i_play) begin
            state_d  = S_ROUND_END;
            foul_d   = 2'b11;
            winner_d = WIN_NONE;
          end else if (i_play[PLAY_L]) begin
            state_d   = S_ROUND_END;
            foul_d    = 2'b01;
            winner_d  = WIN_R;
            score_r_d = score_inc(score_r_q, WIN);
          end else if (i_play[PLAY_R]) begin
            state_d   = S_ROUND_END;
            foul_d    = 2'b10;
            winner_d  = WIN_L;
            score_l_d = score_inc(score_l_q, WIN);
          end else if (w_expire) begin
            state_d     = S_GO;
            react_cnt_d = '0;
          end
        end
        S_GO: begin
          if (|i_play) begin
            state_d = S_ROUND_END;
            foul_d  = 2'b00;
            react_d = react_cnt_q;
            if (&i_play) begin
              winner_d = WIN_NONE;
            end else if (i_play[PLAY_L]) begin
              winner_d  = WIN_L;
              score_l_d = score_inc(score_l_q, WIN);
            end else begin
              winner_d  = WIN_R;
              score_r_d = score_inc(score_r_q, WIN);
            end
          end else if (w_expire) begin
            state_d  = S_ROUND_END;
            winner_d = WIN_NONE;
            foul_d   = 2'b00;
            react_d  = '0;
          end else if (i_tick && (react_cnt_q != REACT_MAX)) begin
            react_cnt_d = react_cnt_q + REACT_W'(1);
          end
        end
        S_ROUND_END: begin
          if (w_expire) begin
            if ((score_l_q == WIN) || (score_r_q == WIN)) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d  = S_READY;
              winner_d = WIN_NONE;
              foul_d   = 2'b00;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    go_d        = (state_d == S_GO);
    game_over_d = (state_d == S_GAME_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      delay_q     <= '0;
      react_cnt_q <= '0;
      react_q     <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      foul_q      <= 2'b00;
      go_q        <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      react_cnt_q <= react_cnt_d;
      react_q     <= react_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      foul_q      <= foul_d;
      go_q        <= go_d;
      game_over_q <= game_over_d;
    end
  end

  assign o_state     = state_q;
  assign o_go        = go_q;
  assign o_score_l   = score_l_q;
  assign o_score_r   = score_r_q;
  assign o_winner    = winner_q;
  assign o_foul      = foul_q;
  assign o_react_ms  = react_q;
  assign o_game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_ctrl
//  Brief    : Directed self-checking bench for game_ctrl with shortened phases.
//  Revision : 1.0
// ============================================================================
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0;
  logic        i_start = 1'b0;
  logic        i_restart = 1'b0;
  logic [1:0]  i_play = 2'b00;
  logic [2:0]  o_state;
  logic        o_go;
  logic [3:0]  o_score_l;
  logic [3:0]  o_score_r;
  logic [1:0]  o_winner;
  logic [1:0]  o_foul;
  logic [13:0] o_react_ms;
  logic        o_game_over;

  int n_chk  = 0;
  int n_pass = 0;
  int n_dly  = 0;

  game_ctrl #(
    .COUNTDOWN_MS (30),
    .RAND_MIN_MS  (10),
    .RAND_MASK    (16'h000F),
    .TIMEOUT_MS   (300),
    .RESULT_MS    (20),
    .WIN_SCORE    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_start     (i_start),
    .i_restart   (i_restart),
    .i_play      (i_play),
    .o_state     (o_state),
    .o_go        (o_go),
    .o_score_l   (o_score_l),
    .o_score_r   (o_score_r),
    .o_winner    (o_winner),
    .o_foul      (o_foul),
    .o_react_ms  (o_react_ms),
    .o_game_over (o_game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock with the given inputs, then sample point 1 ns after the edge.
  task automatic pulse(input logic t, input logic s, input logic r, input logic [1:0] p);
    i_tick = t; i_start = s; i_restart = r; i_play = p;
    @(posedge clk);
    #1;
    i_tick = 1'b0; i_start = 1'b0; i_restart = 1'b0; i_play = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 2'b00);
      pulse(1'b0, 1'b0, 1'b0, 2'b00);
    end
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while ((o_state !== 3'd3) && (n < 64)) begin
      pulse(1'b1, 1'b0, 1'b0, 2'b00);
      n++;
      if (o_state !== 3'd3) pulse(1'b0, 1'b0, 1'b0, 2'b00);
    end
    chk("wait_go", o_state, 3'd3);
  endtask

  initial begin
    // Start strobe during reset is lost.
    i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    i_start = 1'b0;
    chk("rst_state", o_state, 3'd0);
    chk("rst_outs", {o_go, o_score_l, o_score_r, o_winner, o_foul, o_react_ms, o_game_over}, 0);
    pulse(1'b0, 1'b0, 1'b0, 2'b01);
    chk("idle_play_ign", o_state, 3'd0);
    pulse(1'b0, 1'b1, 1'b0, 2'b00);
    chk("start_ready", o_state, 3'd1);

    ticks(29);
    chk("ready_29", o_state, 3'd1);
    pulse(1'b0, 1'b0, 1'b0, 2'b11);
    chk("ready_press_state", o_state, 3'd1);
    chk("ready_press_foul", o_foul, 2'b00);
    ticks(1);
    chk("ready_to_armed", o_state, 3'd2);

    // Left false start.
    pulse(1'b0, 1'b0, 1'b0, 2'b01);
    chk("foul_state", o_state, 3'd4);
    chk("foul_bits", o_foul, 2'b01);
    chk("foul_winner", o_winner, 2'b10);
    chk("foul_score_r", o_score_r, 4'd1);
    chk("foul_score_l", o_score_l, 4'd0);
    ticks(19);
    chk("result_19", o_state, 3'd4);
    ticks(1);
    chk("result_ready", o_state, 3'd1);
    chk("result_clear", {o_winner, o_foul}, 4'b0000);

    // Armed delay in RAND_MIN..RAND_MIN+mask = 10..25.
    ticks(30);
    chk("armed2", o_state, 3'd2);
    wait_go(n_dly);
    chk("delay_min", (n_dly >= 10), 1);
    chk("delay_max", (n_dly <= 25), 1);
    chk("go_lamp", o_go, 1'b1);

    ticks(250);
    pulse(1'b0, 1'b0, 1'b0, 2'b10);
    chk("r_win_state", o_state, 3'd4);
    chk("r_win_winner", o_winner, 2'b10);
    chk("r_win_react", o_react_ms, 14'd250);
    chk("r_win_score", {o_score_l, o_score_r}, {4'd0, 4'd2});
    chk("r_win_go_off", o_go, 1'b0);

    // Tie in GO.
    ticks(20);
    ticks(30);
    wait_go(n_dly);
    ticks(7);
    pulse(1'b0, 1'b0, 1'b0, 2'b11);
    chk("tie_winner", o_winner, 2'b00);
    chk("tie_scores", {o_score_l, o_score_r}, {4'd0, 4'd2});
    chk("tie_react", o_react_ms, 14'd7);

    // Timeout with no press.
    ticks(20);
    ticks(30);
    wait_go(n_dly);
    ticks(299);
    chk("to_299", o_state, 3'd3);
    ticks(1);
    chk("to_state", o_state, 3'd4);
    chk("to_result", {o_winner, o_foul, o_react_ms}, 0);

    // Press on the timeout cycle wins.
    ticks(20);
    ticks(30);
    wait_go(n_dly);
    ticks(299);
    pulse(1'b1, 1'b0, 1'b0, 2'b01);
    chk("to_press_winner", o_winner, 2'b01);
    chk("to_press_score_l", o_score_l, 4'd1);

    // Left takes four more rounds.
    for (int r = 0; r < 4; r++) begin
      ticks(20);
      chk("loop_ready", o_state, 3'd1);
      ticks(30);
      wait_go(n_dly);
      ticks(3);
      pulse(1'b0, 1'b0, 1'b0, 2'b01);
      chk("loop_score_l", o_score_l, 4'(r + 2));
    end
    ticks(19);
    chk("end_19", o_state, 3'd4);
    ticks(1);
    chk("game_over_state", o_state, 3'd5);
    chk("game_over_flag", o_game_over, 1'b1);
    chk("game_over_score", {o_score_l, o_score_r}, {4'd5, 4'd2});
    pulse(1'b0, 1'b0, 1'b0, 2'b01);
    chk("game_over_frozen", o_score_l, 4'd5);
    pulse(1'b0, 1'b1, 1'b0, 2'b00);
    chk("new_game_state", o_state, 3'd1);
    chk("new_game_scores", {o_score_l, o_score_r, o_game_over}, 0);

    // Right false start credits left, then restart beats a press in GO.
    ticks(30);
    pulse(1'b0, 1'b0, 1'b0, 2'b10);
    chk("rfoul_bits", {o_foul, o_winner, o_score_l}, {2'b10, 2'b01, 4'd1});
    ticks(20);
    ticks(30);
    wait_go(n_dly);
    pulse(1'b0, 1'b0, 1'b1, 2'b01);
    chk("restart_state", o_state, 3'd0);
    chk("restart_scores", {o_score_l, o_score_r, o_winner, o_go}, 0);

    // Asynchronous reset mid-ARMED.
    pulse(1'b0, 1'b1, 1'b0, 2'b00);
    ticks(30);
    pulse(1'b0, 1'b0, 1'b0, 2'b01);
    chk("pre_rst_score_r", o_score_r, 4'd1);
    ticks(20);
    ticks(30);
    ticks(3);
    chk("pre_rst_armed", o_state, 3'd2);
    rst = 1'b1;
    #1;
    chk("async_rst", {o_state, o_go, o_score_l, o_score_r, o_winner, o_foul, o_react_ms, o_game_over}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
